// File: rtl/jk_pkg.sv
// Shared types and reset constants for the JK bank arbiter.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } arb_state_t;

    // Wide enough for the largest bank; the top slices to N_BITS.
    localparam logic [63:0] Q_RST  = 64'h0;
    localparam logic [63:0] QB_RST = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with an allow mask and the last_grant register.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic [1:0] i_mask,
    output logic [1:0] o_ready,
    output logic       o_fire,
    output logic       o_gid
);

    logic [1:0] w_veff;
    logic       r_last;

    assign w_veff = i_valid & i_mask;

    // A requester is ready unless the other one is competing; ties go away from r_last.
    always_comb begin
        o_ready = 2'b00;
        if (&w_veff) begin
            o_ready = r_last ? 2'b01 : 2'b10;
        end else begin
            o_ready[0] = i_mask[0] & ~w_veff[1];
            o_ready[1] = i_mask[1] & ~w_veff[0];
        end
    end

    assign o_fire = |(i_valid & o_ready);
    assign o_gid  = i_valid[1] & o_ready[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (o_fire) begin
            r_last <= o_gid;
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of JK bits shared by two command requesters; optional lock via JK_ARB_LOCK_EN.
//   state | meaning
//   IDLE  | round-robin between both requesters
//   LOCK0 | requester 0 owns the bank
//   LOCK1 | requester 1 owns the bank
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int N_BITS   = 8,
    parameter int IDX_W    = $clog2(N_BITS + 1),
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [IDX_W-1:0]  req0_idx,
    input  logic [IDX_W-1:0]  req1_idx,
    input  logic [1:0]        req0_op,
    input  logic [1:0]        req1_op,
    input  logic [1:0]        req_lock,
    output logic [N_BITS-1:0] q,
    output logic [N_BITS-1:0] qb,
    output logic              ack_valid,
    output logic              ack_id,
    output logic              ack_q
);

    logic [1:0]        w_mask;
    logic              w_fire;
    logic              w_gid;
    logic [IDX_W-1:0]  w_idx;
    jk_op_t            w_op;
    logic [N_BITS-1:0] w_hit;
    logic [N_BITS-1:0] w_q_nxt;

    logic [N_BITS-1:0] r_q;
    logic [N_BITS-1:0] r_qb;
    logic              r_ack_valid;
    logic              r_ack_id;
    logic              r_ack_q;

    rr_arb2 u_arb (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_valid (req_valid),
        .i_mask  (w_mask),
        .o_ready (req_ready),
        .o_fire  (w_fire),
        .o_gid   (w_gid)
    );

    assign w_idx = w_gid ? req1_idx : req0_idx;
    assign w_op  = jk_op_t'(w_gid ? req1_op : req0_op);

    // Out-of-range indices match no bit, so they leave q alone and ack with 0.
    always_comb begin
        w_hit   = '0;
        w_q_nxt = r_q;
        for (int i = 0; i < N_BITS; i++) begin
            w_hit[i] = w_fire && (w_idx == IDX_W'(i));
            if (w_hit[i]) begin
                case (w_op)
                    HOLD:    w_q_nxt[i] = r_q[i];
                    CLR:     w_q_nxt[i] = 1'b0;
                    SET:     w_q_nxt[i] = 1'b1;
                    default: w_q_nxt[i] = ~r_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q         <= Q_RST[N_BITS-1:0];
            r_qb        <= QB_RST[N_BITS-1:0];
            r_ack_valid <= 1'b0;
            r_ack_id    <= 1'b0;
            r_ack_q     <= 1'b0;
        end else begin
            r_q         <= w_q_nxt;
            r_qb        <= ~w_q_nxt;
            r_ack_valid <= w_fire;
            if (w_fire) begin
                r_ack_id <= w_gid;
                r_ack_q  <= |(w_q_nxt & w_hit);
            end
        end
    end

`ifdef JK_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             w_lock_req;

    assign w_lock_req = w_gid ? req_lock[1] : req_lock[0];

    always_comb begin
        case (r_state)
            LOCK0:   w_mask = 2'b01;
            LOCK1:   w_mask = 2'b10;
            default: w_mask = 2'b11;
        endcase
    end

    // r_lock_cnt counts down the grants left to the owner; the entering grant is the first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire && w_lock_req && (LOCK_MAX > 1)) begin
                        r_state    <= w_gid ? LOCK1 : LOCK0;
                        r_lock_cnt <= CNT_W'(LOCK_MAX - 1);
                    end
                end
                default: begin
                    if (w_fire && w_lock_req && (r_lock_cnt != CNT_W'(1))) begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_lock_cnt <= '0;
                    end
                end
            endcase
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
    assign w_mask        = 2'b11;
`endif

    assign q         = r_q;
    assign qb        = r_qb;
    assign ack_valid = r_ack_valid;
    assign ack_id    = r_ack_id;
    assign ack_q     = r_ack_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a per-cycle reference model.
module tb_jk_bank_arbiter;

    localparam int NB   = 8;
    localparam int IW   = 4;
    localparam int LMAX = 4;
`ifdef JK_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [IW-1:0] req0_idx, req1_idx;
    logic [1:0]    req0_op, req1_op;
    logic [1:0]    req_lock;
    logic [NB-1:0] q, qb;
    logic          ack_valid, ack_id, ack_q;

    int n_err    = 0;
    int n_checks = 0;

    jk_bank_arbiter #(.N_BITS(NB), .LOCK_MAX(LMAX)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_idx  (req0_idx),
        .req1_idx  (req1_idx),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .req_lock  (req_lock),
        .q         (q),
        .qb        (qb),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .ack_q     (ack_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state as seen after the most recent edge.
    bit            m_known = 1'b0;
    logic [NB-1:0] m_q;
    logic [NB-1:0] m_qb;
    bit            m_ackv, m_ackid, m_ackq;
    int            m_last;
    int            m_owner;
    int            m_grants;

    always @(negedge clk) begin : model
        bit       allow0, allow1, want0, want1;
        logic [1:0] er;
        int       served, idx;
        logic [1:0] op;
        if (m_known) begin
            m_qb = ~m_q;
            chk("q", q, m_q);
            chk("qb", qb, m_qb);
            chk("ack_valid", ack_valid, m_ackv);
            if (m_ackv) begin
                chk("ack_id", ack_id, m_ackid);
                chk("ack_q", ack_q, m_ackq);
            end
            allow0 = (m_owner < 0) || (m_owner == 0);
            allow1 = (m_owner < 0) || (m_owner == 1);
            want0  = req_valid[0] && allow0;
            want1  = req_valid[1] && allow1;
            if (want0 && want1) er = (m_last == 1) ? 2'b01 : 2'b10;
            else                er = {allow1 && !want0, allow0 && !want1};
            chk("req_ready", req_ready, er);
        end
        if (!reset_n) begin
            m_known = 1'b1; m_q = '0; m_ackv = 0; m_ackid = 0; m_ackq = 0;
            m_last = 1; m_owner = -1; m_grants = 0;
        end else if (m_known) begin
            served = -1;
            if (req_valid[0] && er[0]) served = 0;
            else if (req_valid[1] && er[1]) served = 1;
            m_ackv = (served >= 0);
            if (served >= 0) begin
                idx = (served == 1) ? int'(req1_idx) : int'(req0_idx);
                op  = (served == 1) ? req1_op : req0_op;
                if (idx < NB) begin
                    if (op == 2'b01) m_q[idx] = 1'b0;
                    else if (op == 2'b10) m_q[idx] = 1'b1;
                    else if (op == 2'b11) m_q[idx] = ~m_q[idx];
                    m_ackq = m_q[idx];
                end else begin
                    m_ackq = 1'b0;
                end
                m_ackid = (served == 1);
                m_last  = served;
                if (LOCK_ON) begin
                    if (m_owner < 0) begin
                        if (req_lock[served] && LMAX > 1) begin
                            m_owner = served; m_grants = 1;
                        end
                    end else begin
                        m_grants++;
                        if (!req_lock[served] || m_grants == LMAX) m_owner = -1;
                    end
                end
            end else if (m_owner >= 0) begin
                m_owner = -1;
            end
        end
    end

    int g;
    int i0, i1;
    int exp_rr[4] = '{0, 1, 0, 1};
`ifdef JK_ARB_LOCK_EN
    int exp_lk[6] = '{0, 0, 0, 0, 1, 0};
`else
    int exp_lk[6] = '{0, 1, 0, 1, 0, 1};
`endif

    initial begin
        reset_n = 0; req_valid = 0; req_lock = 0;
        req0_idx = 0; req1_idx = 0; req0_op = 0; req1_op = 0;
        cyc(); cyc();
        reset_n = 1;
        cyc();
        chk("rst_q", q, 8'h00);
        chk("rst_qb", qb, 8'hFF);
        chk("rst_ack_valid", ack_valid, 0);
        chk("idle_ready", req_ready, 2'b11);

        // continuous contention
        req_valid = 2'b11; req0_op = 2'b10; req1_op = 2'b10; i0 = 0; i1 = 4;
        for (int k = 0; k < 4; k++) begin
            req0_idx = IW'(i0); req1_idx = IW'(i1);
            @(negedge clk);
            g = req_ready[0] ? 0 : 1;
            chk("rr_grant", g, exp_rr[k]);
            chk("rr_not_both", req_ready == 2'b11, 0);
            cyc();
            if (g == 0) i0++; else i1++;
        end
        req_valid = 0;
        chk("rr_final_q", q, 8'h33);

        reset_n = 0; cyc(); reset_n = 1;

        // set then toggle idx 3
        req_valid = 2'b01; req0_idx = 3; req0_op = 2'b10;
        cyc();
        chk("set_q", q, 8'h08);
        chk("set_ack_valid", ack_valid, 1);
        chk("set_ack_q", ack_q, 1);
        chk("set_ack_id", ack_id, 0);
        req0_op = 2'b11;
        cyc();
        chk("tgl_q", q, 8'h00);
        chk("tgl_ack_q", ack_q, 0);
        req_valid = 0;
        cyc();
        chk("idle_ack_valid", ack_valid, 0);

        // out-of-range index from req1
        req_valid = 2'b10; req1_idx = 2; req1_op = 2'b10;
        cyc();
        req1_idx = 9;
        cyc();
        chk("oor_q", q, 8'h04);
        chk("oor_ack_valid", ack_valid, 1);
        chk("oor_ack_q", ack_q, 0);
        chk("oor_ack_id", ack_id, 1);

        // req0 requests a lock while req1 waits
        req_valid = 2'b11; req_lock = 2'b01;
        req0_idx = 6; req0_op = 2'b10; req1_idx = 7; req1_op = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = req_ready[0] ? 0 : 1;
            chk("lock_grant", g, exp_lk[k]);
            cyc();
        end
        req_valid = 0; req_lock = 0;
        cyc();
        chk("lock_q", q, 8'hC4);

        // reset coinciding with a req0 handshake
        req_valid = 2'b01; req0_idx = 5; req0_op = 2'b10;
        cyc();
        req0_idx = 0;
        reset_n = 0;
        cyc();
        chk("rstmid_q", q, 8'h00);
        chk("rstmid_ack_valid", ack_valid, 0);
        reset_n = 1; req_valid = 2'b11;
        req0_idx = 0; req0_op = 2'b10; req1_idx = 1; req1_op = 2'b10;
        @(negedge clk);
        chk("rstmid_ready", req_ready, 2'b01);
        cyc();
        chk("rstmid_post_q", q, 8'h01);
        chk("rstmid_ack_id", ack_id, 0);
        req_valid = 0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
